// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - vertical timing plus display/writer framebuffer arbiter
//
// Purpose:
//   Generates vertical sync/active timing from end-of-line pulses and arbitrates
//   a single-port framebuffer between the display fetch path (strict priority)
//   and a request/acknowledge pixel writer.
//
// Ports:
//   clk, rst              pixel clock, asynchronous active-high reset
//   ena_line              one-cycle end-of-line pulse from horizontal timing
//   h_display             horizontal active-video flag from horizontal timing
//   wr_req/addr/data      writer request, held until wr_ack
//   wr_ack, wr_err        one-cycle grant; wr_err marks a dropped out-of-range write
//   mem_addr/we/wdata     framebuffer port; mem_rdata returns one cycle later
//   pix_data, pix_valid   fetched pixel to the display
//   v_sync, v_display     vertical sync (active low) and vertical active flag
//   frame_start           one-cycle pulse after the frame wraps

module vga_fb_arbiter #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_LINES = 2,
    parameter int V_BP_LINES   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena_line,
    input  logic        h_display,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        v_sync,
    output logic        v_display,
    output logic        frame_start
);

    localparam int          FB_SIZE      = H_ACTIVE * V_ACTIVE;
    localparam logic [18:0] FB_SIZE_W    = 19'(FB_SIZE);
    localparam logic [18:0] FB_LAST      = 19'(FB_SIZE - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_SYNC_LINES);
    localparam logic [9:0]  V_DISP_START = 10'(V_SYNC_LINES + V_BP_LINES);
    localparam logic [9:0]  V_DISP_END   = 10'(V_SYNC_LINES + V_BP_LINES + V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_v_cnt;
    logic [9:0]  w_v_cnt_nxt;
    logic        r_v_sync;
    logic        r_v_display;
    logic        r_frame_start;

    logic [18:0] r_pix_cnt;
    logic        r_pix_valid;

    logic [18:0] r_mem_addr_hold;
    logic [7:0]  r_mem_wdata_hold;

    logic        w_da;
    logic [18:0] w_mem_addr;
    logic [7:0]  w_mem_wdata;
    logic        w_mem_we;
    logic        w_wr_ack;
    logic        w_wr_err;

    // ------------------------------------------------------------------
    // Vertical timing
    // ------------------------------------------------------------------
    always_comb begin
        w_v_cnt_nxt = r_v_cnt;
        if (ena_line) begin
            if (r_v_cnt == V_LAST) begin
                w_v_cnt_nxt = 10'd0;
            end else begin
                w_v_cnt_nxt = r_v_cnt + 10'd1;
            end
        end
    end

    // Sync and active flags are decoded from the next line count so they
    // change in the same cycle as v_cnt rather than one cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_cnt       <= 10'd0;
            r_v_sync      <= 1'b0;
            r_v_display   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_v_cnt       <= w_v_cnt_nxt;
            r_v_sync      <= (w_v_cnt_nxt >= V_SYNC_END);
            r_v_display   <= (w_v_cnt_nxt >= V_DISP_START) && (w_v_cnt_nxt < V_DISP_END);
            r_frame_start <= ena_line && (r_v_cnt == V_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    assign w_da = h_display & r_v_display;

    // Display always wins; a writer only gets the port in blanking, and
    // never two WRITE cycles back to back.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_da) begin
            w_state_nxt = ST_FETCH;
        end else if ((r_state != ST_WRITE) && wr_req) begin
            w_state_nxt = ST_WRITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Port outputs decode straight from the state register so that an
    // asynchronous reset removes a WRITE grant immediately.
    always_comb begin
        w_mem_addr  = r_mem_addr_hold;
        w_mem_wdata = r_mem_wdata_hold;
        w_mem_we    = 1'b0;
        w_wr_ack    = 1'b0;
        w_wr_err    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_addr = r_pix_cnt;
            end
            ST_WRITE: begin
                w_mem_addr  = wr_addr;
                w_mem_wdata = wr_data;
                w_wr_ack    = 1'b1;
                if (wr_addr < FB_SIZE_W) begin
                    w_mem_we = 1'b1;
                end else begin
                    w_wr_err = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch address counter, held port values, read-data qualifier
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt        <= 19'd0;
            r_pix_valid      <= 1'b0;
            r_mem_addr_hold  <= 19'd0;
            r_mem_wdata_hold <= 8'd0;
        end else begin
            if (r_frame_start) begin
                r_pix_cnt <= 19'd0;
            end else if ((r_state == ST_FETCH) && (r_pix_cnt != FB_LAST)) begin
                r_pix_cnt <= r_pix_cnt + 19'd1;
            end
            r_pix_valid      <= (r_state == ST_FETCH);
            r_mem_addr_hold  <= w_mem_addr;
            r_mem_wdata_hold <= w_mem_wdata;
        end
    end

    assign mem_addr    = w_mem_addr;
    assign mem_wdata   = w_mem_wdata;
    assign mem_we      = w_mem_we;
    assign wr_ack      = w_wr_ack;
    assign wr_err      = w_wr_err;
    assign pix_valid   = r_pix_valid;
    assign pix_data    = r_pix_valid ? mem_rdata : 8'd0;
    assign v_sync      = r_v_sync;
    assign v_display   = r_v_display;
    assign frame_start = r_frame_start;

endmodule
